// File: rtl/ib_lut_share_arb.sv
// rtl/ib_lut_share_arb.sv - round-robin sharing of one IB-LUT read port between VNU lanes
//
// Purpose: grants at most one LUT lookup per cycle in rotating priority order,
// follows each lookup through the fixed LUT read latency, applies the sym2int
// sign correction to the returned map word and strobes it back to its lane.
//
// Ports:
//   sys_clk      clock
//   rst          synchronous active-high reset
//   req_i        per-lane lookup request, held until granted
//   req_addr_i   per-lane LUT address, lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_sign_i   per-lane raw sign
//   gnt_o        one-hot grant, combinational in the request cycle
//   lut_ren_o    shared LUT read enable
//   lut_raddr_o  shared LUT read address (0 when idle)
//   lut_rdata_i  LUT read data, valid LUT_LAT cycles after lut_ren_o
//   rsp_valid_o  one-hot registered response strobe
//   rsp_msg_o    sign-corrected message, qualified by rsp_valid_o
//   busy_o       high while any lookup is in flight
//   stall_cnt_o  per-lane saturating 16-bit stall counters
//                (only with IB_LUT_ARB_STALL_CNT_EN defined)

module ib_lut_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int MSG_WIDTH  = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int LUT_LAT    = 2
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0]            req_sign_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          lut_ren_o,
   output logic [ADDR_WIDTH-1:0]         lut_raddr_o,
   input  logic [MSG_WIDTH-1:0]          lut_rdata_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [MSG_WIDTH-1:0]          rsp_msg_o,
   output logic                          busy_o
`ifdef IB_LUT_ARB_STALL_CNT_EN
   ,
   output logic [NUM_REQ*16-1:0]         stall_cnt_o
`endif
);

   localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // rotating priority pointer
   logic [LANE_W-1:0] ptr_q, ptr_d;

   // tracking pipeline, one entry per LUT latency cycle
   logic [LUT_LAT-1:0]             stg_vld_q,  stg_vld_d;
   logic [LUT_LAT-1:0][LANE_W-1:0] stg_lane_q, stg_lane_d;
   logic [LUT_LAT-1:0]             stg_sign_q, stg_sign_d;

   // registered response
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [MSG_WIDTH-1:0] rsp_msg_q,   rsp_msg_d;

   // arbitration results
   logic [NUM_REQ-1:0]    gnt;
   logic                  gnt_any;
   logic [LANE_W-1:0]     gnt_idx;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic                  gnt_sign;

   // Two passes instead of a modulo index: first the lanes at or above the
   // pointer, then wrap around to the lanes below it.
   always_comb begin
      gnt      = '0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_addr = '0;
      gnt_sign = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req_i[i] && (i >= int'(ptr_q))) begin
            gnt_any  = 1'b1;
            gnt[i]   = 1'b1;
            gnt_idx  = LANE_W'(i);
            gnt_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_sign = req_sign_i[i];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req_i[i]) begin
            gnt_any  = 1'b1;
            gnt[i]   = 1'b1;
            gnt_idx  = LANE_W'(i);
            gnt_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_sign = req_sign_i[i];
         end
      end
      // nothing may be issued to the LUT while the tracker is being cleared
      if (rst) begin
         gnt      = '0;
         gnt_any  = 1'b0;
         gnt_idx  = '0;
         gnt_addr = '0;
         gnt_sign = 1'b0;
      end
   end

   assign gnt_o       = gnt;
   assign lut_ren_o   = gnt_any;
   assign lut_raddr_o = gnt_addr;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == LANE_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // The pipeline shifts unconditionally so the last stage lines up exactly
   // with the cycle the LUT presents data for that entry.
   always_comb begin
      stg_vld_d     = stg_vld_q;
      stg_lane_d    = stg_lane_q;
      stg_sign_d    = stg_sign_q;
      stg_vld_d[0]  = gnt_any;
      stg_lane_d[0] = gnt_idx;
      stg_sign_d[0] = gnt_sign;
      for (int i = 1; i < LUT_LAT; i++) begin
         stg_vld_d[i]  = stg_vld_q[i-1];
         stg_lane_d[i] = stg_lane_q[i-1];
         stg_sign_d[i] = stg_sign_q[i-1];
      end
   end

   // sym2int: a stored sign of 0 inverts the map word MSB, 1 passes it through
   always_comb begin
      rsp_valid_d = '0;
      rsp_msg_d   = rsp_msg_q;
      if (stg_vld_q[LUT_LAT-1]) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            rsp_valid_d[k] = (stg_lane_q[LUT_LAT-1] == LANE_W'(k));
         end
         rsp_msg_d = {stg_sign_q[LUT_LAT-1] ? lut_rdata_i[MSG_WIDTH-1]
                                            : ~lut_rdata_i[MSG_WIDTH-1],
                      lut_rdata_i[MSG_WIDTH-2:0]};
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ptr_q       <= '0;
         stg_vld_q   <= '0;
         stg_lane_q  <= '0;
         stg_sign_q  <= '0;
         rsp_valid_q <= '0;
         rsp_msg_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         stg_vld_q   <= stg_vld_d;
         stg_lane_q  <= stg_lane_d;
         stg_sign_q  <= stg_sign_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_msg_q   <= rsp_msg_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_msg_o   = rsp_msg_q;
   assign busy_o      = (|stg_vld_q) | (|rsp_valid_q);

`ifdef IB_LUT_ARB_STALL_CNT_EN
   logic [NUM_REQ-1:0][15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req_i[k] && !gnt[k] && (stall_cnt_q[k] != 16'hFFFF)) begin
            stall_cnt_d[k] = stall_cnt_q[k] + 16'd1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ib_lut_share_arb.sv
// tb/tb_ib_lut_share_arb.sv - directed vector bench for ib_lut_share_arb

module tb_ib_lut_share_arb;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic [3:0]  req_i;
   logic [31:0] req_addr_i;
   logic [3:0]  req_sign_i;
   logic [3:0]  gnt_o;
   logic        lut_ren_o;
   logic [7:0]  lut_raddr_o;
   logic [3:0]  lut_rdata_i;
   logic [3:0]  rsp_valid_o;
   logic [3:0]  rsp_msg_o;
   logic        busy_o;
`ifdef IB_LUT_ARB_STALL_CNT_EN
   logic [63:0] stall_cnt_o;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 sys_clk = ~sys_clk;

   ib_lut_share_arb #(
      .NUM_REQ(4), .MSG_WIDTH(4), .ADDR_WIDTH(8), .LUT_LAT(2)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .req_i       (req_i),
      .req_addr_i  (req_addr_i),
      .req_sign_i  (req_sign_i),
      .gnt_o       (gnt_o),
      .lut_ren_o   (lut_ren_o),
      .lut_raddr_o (lut_raddr_o),
      .lut_rdata_i (lut_rdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_msg_o   (rsp_msg_o),
      .busy_o      (busy_o)
`ifdef IB_LUT_ARB_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   // LUT content: 0x3C -> 0101, 0x10 -> 1011, 0x21 -> 1001, 0x4E -> 0000
   function automatic logic [3:0] lut_fn(input logic [7:0] a);
      return a[3:0] ^ a[7:4] ^ 4'hA;
   endfunction

   // two-cycle read latency memory model
   logic [3:0] lut_p1 = 4'h0;
   logic [3:0] lut_p2 = 4'h0;
   always @(posedge sys_clk) begin
      lut_p1 <= lut_ren_o ? lut_fn(lut_raddr_o) : 4'h0;
      lut_p2 <= lut_p1;
   end
   assign lut_rdata_i = lut_p2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] sign);
      @(posedge sys_clk);
      #1;
      req_i      = req;
      req_sign_i = sign;
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] sign;
      logic [3:0] gnt;
      logic [7:0] raddr;
      logic [3:0] rv;
      logic [3:0] msg;
      logic       busy;
   } vec_t;

   vec_t vec [0:36];

   initial begin
      // lane addresses: 0x10, 0x21, 0x3C, 0x4E
      req_addr_i = 32'h4E3C_2110;
      rst        = 1'b1;
      req_i      = 4'h0;
      req_sign_i = 4'h0;

      //            req      sign     gnt      raddr  rv       msg      busy
      // single lookup lane 2, sign 0
      vec[0]  = '{4'b0100, 4'b1010, 4'b0100, 8'h3C, 4'b0000, 4'h0, 1'b0};
      vec[1]  = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b1};
      vec[2]  = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b1};
      vec[3]  = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0100, 4'hD, 1'b1};
      vec[4]  = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b0};
      // single lookup lane 2, sign 1
      vec[5]  = '{4'b0100, 4'b1110, 4'b0100, 8'h3C, 4'b0000, 4'h0, 1'b0};
      vec[6]  = '{4'b0000, 4'b1110, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b1};
      vec[7]  = '{4'b0000, 4'b1110, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b1};
      vec[8]  = '{4'b0000, 4'b1110, 4'b0000, 8'h00, 4'b0100, 4'h5, 1'b1};
      vec[9]  = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b0};
      // pointer wrap: lane 3, then lanes 0 and 3 -> 0 first, then 3
      vec[10] = '{4'b1000, 4'b1010, 4'b1000, 8'h4E, 4'b0000, 4'h0, 1'b0};
      vec[11] = '{4'b1001, 4'b1010, 4'b0001, 8'h10, 4'b0000, 4'h0, 1'b1};
      vec[12] = '{4'b1000, 4'b1010, 4'b1000, 8'h4E, 4'b0000, 4'h0, 1'b1};
      vec[13] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b1000, 4'h0, 1'b1};
      vec[14] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0001, 4'h3, 1'b1};
      vec[15] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b1000, 4'h0, 1'b1};
      vec[16] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b0};
      // all four lanes requesting for 8 cycles
      vec[17] = '{4'b1111, 4'b1010, 4'b0001, 8'h10, 4'b0000, 4'h0, 1'b0};
      vec[18] = '{4'b1111, 4'b1010, 4'b0010, 8'h21, 4'b0000, 4'h0, 1'b1};
      vec[19] = '{4'b1111, 4'b1010, 4'b0100, 8'h3C, 4'b0000, 4'h0, 1'b1};
      vec[20] = '{4'b1111, 4'b1010, 4'b1000, 8'h4E, 4'b0001, 4'h3, 1'b1};
      vec[21] = '{4'b1111, 4'b1010, 4'b0001, 8'h10, 4'b0010, 4'h9, 1'b1};
      vec[22] = '{4'b1111, 4'b1010, 4'b0010, 8'h21, 4'b0100, 4'hD, 1'b1};
      vec[23] = '{4'b1111, 4'b1010, 4'b0100, 8'h3C, 4'b1000, 4'h0, 1'b1};
      vec[24] = '{4'b1111, 4'b1010, 4'b1000, 8'h4E, 4'b0001, 4'h3, 1'b1};
      vec[25] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0010, 4'h9, 1'b1};
      vec[26] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0100, 4'hD, 1'b1};
      vec[27] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b1000, 4'h0, 1'b1};
      vec[28] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b0};
      // single lane held continuously is granted every cycle
      vec[29] = '{4'b0010, 4'b1010, 4'b0010, 8'h21, 4'b0000, 4'h0, 1'b0};
      vec[30] = '{4'b0010, 4'b1010, 4'b0010, 8'h21, 4'b0000, 4'h0, 1'b1};
      vec[31] = '{4'b0010, 4'b1010, 4'b0010, 8'h21, 4'b0000, 4'h0, 1'b1};
      vec[32] = '{4'b0010, 4'b1010, 4'b0010, 8'h21, 4'b0010, 4'h9, 1'b1};
      vec[33] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0010, 4'h9, 1'b1};
      vec[34] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0010, 4'h9, 1'b1};
      vec[35] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0010, 4'h9, 1'b1};
      vec[36] = '{4'b0000, 4'b1010, 4'b0000, 8'h00, 4'b0000, 4'h0, 1'b0};

      // reset with requests pending: nothing may be granted
      repeat (3) @(posedge sys_clk);
      #1;
      req_i = 4'b1111;
      @(negedge sys_clk);
      chk("rst_gnt",   32'(gnt_o),       32'h0);
      chk("rst_ren",   32'(lut_ren_o),   32'h0);
      chk("rst_rv",    32'(rsp_valid_o), 32'h0);
      chk("rst_msg",   32'(rsp_msg_o),   32'h0);
      chk("rst_busy",  32'(busy_o),      32'h0);
      @(posedge sys_clk);
      #1;
      rst   = 1'b0;
      req_i = 4'b0000;

      // idle for 20 cycles
      for (int c = 0; c < 20; c++) begin
         @(negedge sys_clk);
         chk("idle_gnt",  32'(gnt_o),       32'h0);
         chk("idle_ren",  32'(lut_ren_o),   32'h0);
         chk("idle_rv",   32'(rsp_valid_o), 32'h0);
         chk("idle_busy", 32'(busy_o),      32'h0);
      end

      // table-driven vectors
      for (int i = 0; i <= 36; i++) begin
         drive(vec[i].req, vec[i].sign);
         @(negedge sys_clk);
         chk($sformatf("v%0d_gnt", i),   32'(gnt_o),       32'(vec[i].gnt));
         chk($sformatf("v%0d_ren", i),   32'(lut_ren_o),   32'(|vec[i].gnt));
         chk($sformatf("v%0d_raddr", i), 32'(lut_raddr_o), 32'(vec[i].raddr));
         chk($sformatf("v%0d_rv", i),    32'(rsp_valid_o), 32'(vec[i].rv));
         chk($sformatf("v%0d_busy", i),  32'(busy_o),      32'(vec[i].busy));
         if (vec[i].rv != 4'b0000) begin
            chk($sformatf("v%0d_msg", i), 32'(rsp_msg_o), 32'(vec[i].msg));
         end
      end

      // reset one cycle after two grants are issued (pointer now at lane 2)
      drive(4'b1111, 4'b1010);
      @(negedge sys_clk);
      chk("mid_gnt_a", 32'(gnt_o), 32'b0100);
      drive(4'b1111, 4'b1010);
      @(negedge sys_clk);
      chk("mid_gnt_b", 32'(gnt_o), 32'b1000);
      drive(4'b1111, 4'b1010);
      rst = 1'b1;
      @(negedge sys_clk);
      chk("mid_rst_gnt", 32'(gnt_o),     32'h0);
      chk("mid_rst_ren", 32'(lut_ren_o), 32'h0);
      drive(4'b0000, 4'b1010);
      rst = 1'b0;
      @(negedge sys_clk);
      chk("post_rst_busy", 32'(busy_o),      32'h0);
      chk("post_rst_rv",   32'(rsp_valid_o), 32'h0);
      chk("post_rst_msg",  32'(rsp_msg_o),   32'h0);
      for (int c = 0; c < 5; c++) begin
         drive(4'b0000, 4'b1010);
         @(negedge sys_clk);
         chk("post_rst_no_rsp",  32'(rsp_valid_o), 32'h0);
         chk("post_rst_no_busy", 32'(busy_o),      32'h0);
      end
      // pointer back at 0
      drive(4'b1111, 4'b1010);
      @(negedge sys_clk);
      chk("post_rst_ptr0", 32'(gnt_o), 32'b0001);
      drive(4'b0000, 4'b1010);

`ifdef IB_LUT_ARB_STALL_CNT_EN
      rst = 1'b1;
      drive(4'b0000, 4'b1010);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive(4'b0011, 4'b1010);
      end
      drive(4'b0000, 4'b1010);
      @(negedge sys_clk);
      chk("stall_l0", 32'(stall_cnt_o[15:0]),  32'd5);
      chk("stall_l1", 32'(stall_cnt_o[31:16]), 32'd5);
      chk("stall_l2", 32'(stall_cnt_o[47:32]), 32'd0);
      chk("stall_l3", 32'(stall_cnt_o[63:48]), 32'd0);
`endif

      repeat (4) @(posedge sys_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
